// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding, PC width and
// the sequential increment.
package pc_sequencer_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_EXC   = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  // Redirect targets are always word aligned.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_sequencer_adder.sv
// Sequential PC increment; wraps modulo 2^32.
module pc_adder
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] sum
);
  assign sum = pc + PC_INC;
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and control FSM. The PC register lives outside; pc_next
// feeds it combinationally so redirects land one cycle later.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        flush,
  output logic [31:0] epc,
  output logic [1:0]  state
);
  seq_state_t state_q, state_d;
  logic       exc_cnt;
  logic       exc_take;
  logic [31:0] pc_inc;

  pc_adder u_adder (.pc(pc_cur), .sum(pc_inc));

  assign state = state_q;

  always_comb begin
    state_d  = state_q;
    pc_next  = pc_inc;
    flush    = 1'b0;
    exc_take = 1'b0;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_req) begin
            exc_take = 1'b1;
          end else if (halt_req) begin
            pc_next = pc_cur;
            flush   = 1'b1;
            state_d = ST_HALT;
          end else if (stall) begin
            pc_next = pc_cur;
          end else if (jump) begin
            pc_next = word_align(jump_target);
            flush   = 1'b1;
            state_d = ST_FLUSH;
          end else if (branch_taken) begin
            pc_next = word_align(branch_target);
            flush   = 1'b1;
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush = 1'b1;
          if (exc_req)    exc_take = 1'b1;
          else if (stall) pc_next = pc_cur;
          else            state_d = ST_RUN;
        end
        ST_EXC: begin
          // Requests are deliberately ignored until the handler entry settles.
          flush = 1'b1;
          if (exc_cnt) state_d = ST_RUN;
        end
        default: begin
          pc_next = pc_cur;
          if (exc_req)     exc_take = 1'b1;
          else if (resume) state_d = ST_RUN;
        end
      endcase
      if (exc_take) begin
        pc_next = EXC_VECTOR;
        flush   = 1'b1;
        state_d = ST_EXC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      epc     <= '0;
      exc_cnt <= 1'b0;
    end else begin
      state_q <= state_d;
      if (exc_take) epc <= pc_cur;
      exc_cnt <= (state_q == ST_EXC) ? ~exc_cnt : 1'b0;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Vector table plus hand sequences for pc_sequencer; expected values are
// queued at drive time and compared mid-cycle.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur, branch_target, jump_target;
  logic        stall, branch_taken, jump, exc_req, halt_req, resume;
  logic [31:0] pc_next, epc;
  logic        flush;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        stl, br, jmp, exc, hlt, res;
    logic [31:0] bt, jt;
    logic [31:0] e_pc;
    logic        e_fl;
    logic [1:0]  e_st;
    logic [31:0] e_epc;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
    .halt_req(halt_req), .resume(resume), .pc_next(pc_next),
    .flush(flush), .epc(epc), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic stl, br, jmp, exc, hlt, res,
                              input logic [31:0] bt, jt, e_pc, input logic e_fl,
                              input logic [1:0] e_st, input logic [31:0] e_epc);
    vec_t v;
    v.pc = pc; v.stl = stl; v.br = br; v.jmp = jmp; v.exc = exc; v.hlt = hlt; v.res = res;
    v.bt = bt; v.jt = jt; v.e_pc = e_pc; v.e_fl = e_fl; v.e_st = e_st; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    pc_cur = v.pc; stall = v.stl; branch_taken = v.br; jump = v.jmp;
    exc_req = v.exc; halt_req = v.hlt; resume = v.res;
    branch_target = v.bt; jump_target = v.jt;
    sb.push_back(v);
  endtask

  task automatic compare_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".pc_next"}, pc_next, e.e_pc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e.e_fl});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, e.e_st});
    chk({tag, ".epc"}, epc, e.e_epc);
  endtask

  // Drive just after a rising edge, compare on the falling edge, advance.
  task automatic cycle(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    compare_out(tag);
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] R = 2'd0, F = 2'd1, X = 2'd2, H = 2'd3;

  initial begin
    reset = 1'b1;
    drive(mk(32'h1234, 0,0,0,0,0,0, 0, 0, 32'h0, 0, R, 32'h0));
    #2 compare_out("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    //            pc          stl br jmp exc hlt res  bt          jt          e_pc          fl st  epc
    tbl.push_back(mk(32'h0,    0,0,0,0,0,0, 0,           0,           32'h4,        0, R, 0));
    tbl.push_back(mk(32'h4,    0,0,0,0,0,0, 0,           0,           32'h8,        0, R, 0));
    tbl.push_back(mk(32'h8,    0,0,0,0,0,0, 0,           0,           32'hC,        0, R, 0));
    tbl.push_back(mk(32'hC,    0,0,0,0,0,0, 0,           0,           32'h10,       0, R, 0));
    tbl.push_back(mk(32'h100,  0,1,0,0,0,0, 32'h203,     0,           32'h200,      1, R, 0));
    tbl.push_back(mk(32'h200,  0,0,0,0,0,0, 0,           0,           32'h204,      1, F, 0));
    tbl.push_back(mk(32'h204,  0,0,0,0,0,0, 0,           0,           32'h208,      0, R, 0));
    tbl.push_back(mk(32'h208,  1,1,1,0,0,0, 32'h200,     32'h400,     32'h208,      0, R, 0));
    tbl.push_back(mk(32'h208,  0,1,1,0,0,0, 32'h200,     32'h400,     32'h400,      1, R, 0));
    tbl.push_back(mk(32'h400,  1,0,0,0,0,0, 0,           0,           32'h400,      1, F, 0));
    tbl.push_back(mk(32'h400,  0,0,0,0,0,0, 0,           0,           32'h404,      1, F, 0));
    tbl.push_back(mk(32'h404,  0,0,0,0,0,0, 0,           0,           32'h408,      0, R, 0));
    tbl.push_back(mk(32'h3C,   0,0,0,1,0,0, 0,           0,           32'h80,       1, R, 0));
    tbl.push_back(mk(32'h80,   0,0,0,1,0,0, 0,           0,           32'h84,       1, X, 32'h3C));
    tbl.push_back(mk(32'h84,   0,0,0,1,0,0, 0,           0,           32'h88,       1, X, 32'h3C));
    tbl.push_back(mk(32'h88,   0,0,0,0,0,0, 0,           0,           32'h8C,       0, R, 32'h3C));
    tbl.push_back(mk(32'hFFFF_FFFC, 0,0,0,0,0,0, 0,      0,           32'h0,        0, R, 32'h3C));
    tbl.push_back(mk(32'h10,   0,0,1,0,0,0, 0,           32'h503,     32'h500,      1, R, 32'h3C));
    tbl.push_back(mk(32'h500,  0,0,0,1,0,0, 0,           0,           32'h80,       1, F, 32'h3C));
    tbl.push_back(mk(32'h80,   0,0,0,0,0,0, 0,           0,           32'h84,       1, X, 32'h500));
    tbl.push_back(mk(32'h84,   0,0,0,0,0,0, 0,           0,           32'h88,       1, X, 32'h500));
    tbl.push_back(mk(32'h88,   0,0,0,0,0,0, 0,           0,           32'h8C,       0, R, 32'h500));
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], $sformatf("vec%0d", i));

    // Halt: entry, ten held cycles, resume, then sequential again.
    cycle(mk(32'h50, 0,0,0,0,1,0, 0, 0, 32'h50, 1, R, 32'h500), "halt_entry");
    for (int i = 0; i < 10; i++)
      cycle(mk(32'h50, (i == 3), 0, (i == 5), 0, 0, 0, 0, 32'h900, 32'h50, 0, H, 32'h500),
            $sformatf("halt_hold%0d", i));
    cycle(mk(32'h50, 0,0,0,0,0,1, 0, 0, 32'h50, 0, H, 32'h500), "halt_resume");
    cycle(mk(32'h50, 0,0,0,0,0,0, 0, 0, 32'h54, 0, R, 32'h500), "after_resume");

    // Exception wins over resume while halted.
    cycle(mk(32'h60, 0,0,0,0,1,0, 0, 0, 32'h60, 1, R, 32'h500), "halt2_entry");
    cycle(mk(32'h60, 0,0,0,1,0,1, 0, 0, 32'h80, 1, H, 32'h500), "halt_exc");
    cycle(mk(32'h80, 0,0,0,0,0,0, 0, 0, 32'h84, 1, X, 32'h60), "halt_exc_x1");

    // Asynchronous reset in the middle of EXC, checked with no clock edge.
    #2 reset = 1'b1;
    drive(mk(32'h84, 0,0,0,0,0,0, 0, 0, 32'h0, 0, R, 32'h0));
    #1 compare_out("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(mk(32'h0, 0,0,0,0,0,0, 0, 0, 32'h4, 0, R, 0), "post_reset0");
    cycle(mk(32'h4, 0,0,0,0,0,0, 0, 0, 32'h8, 0, R, 0), "post_reset1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, PC value driven on pc_next while reset is asserted.
REQ-002 Parameter EXC_VECTOR, 32'h0000_0080, exception handler entry address.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pc_cur  in  32  current PC, taken from the PC register output.
REQ-006 stall  in  1  pipeline hazard; PC holds.
REQ-007 branch_taken  in  1  resolved taken branch.
REQ-008 branch_target  in  32  branch destination.
REQ-009 jump  in  1  unconditional jump.
REQ-010 jump_target  in  32  jump destination.
REQ-011 exc_req  in  1  exception or interrupt request, level.
REQ-012 halt_req  in  1  enter HALT at the next boundary.
REQ-013 resume  in  1  leave HALT.
REQ-014 pc_next  out  32  next PC, driving the PC register input.
REQ-015 flush  out  1  kill the instruction in fetch/decode.
REQ-016 epc  out  32  PC saved at exception entry.
REQ-017 state  out  2  FSM state: RUN=0, FLUSH=1, EXC=2, HALT=3.

Function
REQ-018 pc_next SHALL be combinational from state, inputs and pc_cur; it SHALL equal the PC register value one cycle later, giving 1-cycle redirect latency.
REQ-019 In RUN, priority SHALL be: exc_req > halt_req > stall > jump > branch_taken > sequential.
REQ-020 Sequential: pc_next = pc_cur + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-021 Stall: pc_next = pc_cur, flush = 0, state stays RUN.
REQ-022 Jump or branch: pc_next = target with bits[1:0] forced to 00; flush asserted that cycle; next state FLUSH.
REQ-023 FLUSH: lasts 1 cycle, flush = 1, pc_next = pc_cur + 4, then RUN; stall in FLUSH holds PC and extends FLUSH; exc_req in FLUSH takes the exception path.
REQ-024 Exception entry: epc <= pc_cur, pc_next = EXC_VECTOR, flush = 1, next state EXC.
REQ-025 EXC: lasts 2 cycles via an internal 1-bit counter, flush = 1, PC advances sequentially from EXC_VECTOR, then RUN; exc_req is ignored while in EXC.
REQ-026 HALT entry: pc_next = pc_cur, flush = 1 on the entry cycle only.
REQ-027 In HALT: pc_next = pc_cur and flush = 0; resume returns to RUN on the next cycle; exc_req in HALT takes the exception path with epc = pc_cur; resume and exc_req together resolve to the exception path.
REQ-028 When jump and branch_taken are asserted together, the jump SHALL win and branch_target SHALL be ignored.
REQ-029 epc SHALL change only on exception entry.

Reset
REQ-030 While reset = 1: state = RUN, pc_next = RESET_VECTOR, flush = 0, epc = 0, EXC counter = 0.
REQ-031 Reset asserted mid-FLUSH, mid-EXC or in HALT SHALL abort immediately and asynchronously; no pending redirect survives reset.
REQ-032 On the first edge after reset deassertion, the block SHALL resume sequential operation from pc_cur.

Structure
REQ-033 A shared package SHALL hold the state encoding, the PC width (32) and the increment constant (4).
REQ-034 The block SHALL consist of one FSM plus next-PC mux in a single module, with a sub-module pc_adder for the +4 increment; there SHALL be no PC storage inside the block.

Verification
REQ-035 Reset release, no requests -> pc_next 0, 4, 8, 12 on successive cycles; flush = 0.
REQ-036 pc_cur = 0x100, branch_taken = 1, branch_target = 0x203 -> pc_next = 0x200; flush = 1 for 2 cycles; state RUN -> FLUSH -> RUN.
REQ-037 jump (0x400) and branch_taken (0x200) together while stall = 1 -> PC holds; after stall drops, pc_next = 0x400.
REQ-038 exc_req at pc_cur = 0x3C -> epc = 0x3C, pc_next = 0x80 then 0x84; flush high for 3 cycles; a second exc_req in EXC is ignored.
REQ-039 halt_req at pc_cur = 0x50 -> PC holds at 0x50 for 10 cycles; resume -> 0x54 next.
REQ-040 pc_cur = 0xFFFF_FFFC sequential -> pc_next = 0; reset asserted in EXC -> state RUN and pc_next = RESET_VECTOR with no clock edge.
